// File: rtl/key_cond_pkg.sv
// Shared definitions for the push-button conditioning path: FSM state
// encoding, default 12 MHz timing constants and the counter-width helper.
package key_cond_pkg;

    // Press-classification FSM states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HELD = 2'd1,
        ST_LONG = 2'd2
    } key_state_e;

    // Default timing at 12 MHz
    localparam int DEF_DEBOUNCE_CYCLES = 120000;   // 10 ms
    localparam int DEF_LONG_CYCLES     = 6000000;  // 0.5 s
    localparam int DEF_REPEAT_CYCLES   = 1200000;  // 100 ms
    localparam bit DEF_KEY_ACTIVE_LOW  = 1'b1;

    // Width of a counter that has to hold values up to 'cycles'
    function automatic int cnt_width(input int cycles);
        return $clog2(cycles) + 1;
    endfunction

endpackage

// File: rtl/key_conditioner_if.sv
// Button pin plus the conditioned key level and event pulses.
// The conditioner connects through 'master' (it drives the outputs);
// the consumer side (sound/blink stages, bench) uses 'slave'.
interface key_conditioner_if;
    logic key_raw;
    logic key_level;
    logic press_pulse;
    logic release_pulse;
    logic short_press;
    logic long_press;
    logic repeat_pulse;

    modport master (
        input  key_raw,
        output key_level,
        output press_pulse,
        output release_pulse,
        output short_press,
        output long_press,
        output repeat_pulse
    );

    modport slave (
        output key_raw,
        input  key_level,
        input  press_pulse,
        input  release_pulse,
        input  short_press,
        input  long_press,
        input  repeat_pulse
    );
endinterface

// File: rtl/key_debounce.sv
// Two-flop synchroniser on the raw pin followed by a stability counter.
// key_level is active-high and only changes after the synchronised pin
// has disagreed with it for DEBOUNCE_CYCLES consecutive clocks.
module key_debounce
    import key_cond_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter bit KEY_ACTIVE_LOW  = DEF_KEY_ACTIVE_LOW
) (
    input  logic clk12MHz,
    input  logic rst_n,
    input  logic key_raw,
    output logic key_level
);

    localparam int              DB_W    = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    logic            sync1_q;
    logic            sync2_q;
    logic            key_sync;
    logic            level_q;
    logic            level_d;
    logic [DB_W-1:0] db_cnt_q;
    logic [DB_W-1:0] db_cnt_d;

    // Normalise to pressed = 1 regardless of pin polarity
    assign key_sync  = sync2_q ^ KEY_ACTIVE_LOW;
    assign key_level = level_q;

    // Count consecutive disagreements; accept the new level on the last one
    always_comb begin
        level_d  = level_q;
        db_cnt_d = db_cnt_q;
        if (key_sync == level_q) begin
            db_cnt_d = '0;
        end else if (db_cnt_q == DB_LAST) begin
            level_d  = ~level_q;
            db_cnt_d = '0;
        end else begin
            db_cnt_d = db_cnt_q + DB_W'(1);
        end
    end

    // Synchroniser and debounce state; sync flops reset to the idle pin level
    always_ff @(posedge clk12MHz or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q  <= KEY_ACTIVE_LOW;
            sync2_q  <= KEY_ACTIVE_LOW;
            level_q  <= 1'b0;
            db_cnt_q <= '0;
        end else begin
            sync1_q  <= key_raw;
            sync2_q  <= sync1_q;
            level_q  <= level_d;
            db_cnt_q <= db_cnt_d;
        end
    end

endmodule

// File: rtl/key_conditioner.sv
// Push-button conditioner: debounced level plus registered press, release,
// short/long classification and auto-repeat pulses. press_pulse feeds the
// sound stage start, key_level replaces the raw key for the blink stage.
module key_conditioner
    import key_cond_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int LONG_CYCLES     = DEF_LONG_CYCLES,
    parameter int REPEAT_CYCLES   = DEF_REPEAT_CYCLES,
    parameter bit KEY_ACTIVE_LOW  = DEF_KEY_ACTIVE_LOW
) (
    input  logic               clk12MHz,
    input  logic               rst_n,
    key_conditioner_if.master  kif
);

    localparam int                HOLD_W     = cnt_width(LONG_CYCLES);
    localparam int                REP_W      = cnt_width(REPEAT_CYCLES);
    localparam int                REP_LAST_I = (REPEAT_CYCLES > 0) ? (REPEAT_CYCLES - 1) : 0;
    localparam logic [HOLD_W-1:0] HOLD_LAST  = HOLD_W'(LONG_CYCLES - 1);
    localparam logic [REP_W-1:0]  REP_LAST   = REP_W'(REP_LAST_I);

    logic              level_s;
    key_state_e        state_q;
    key_state_e        state_d;
    logic [HOLD_W-1:0] hold_cnt_q;
    logic [HOLD_W-1:0] hold_cnt_d;
    logic [REP_W-1:0]  rep_cnt_q;
    logic [REP_W-1:0]  rep_cnt_d;
    logic              press_q,   press_d;
    logic              release_q, release_d;
    logic              short_q,   short_d;
    logic              long_q,    long_d;
    logic              repeat_q,  repeat_d;

    key_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .KEY_ACTIVE_LOW  (KEY_ACTIVE_LOW)
    ) u_debounce (
        .clk12MHz  (clk12MHz),
        .rst_n     (rst_n),
        .key_raw   (kif.key_raw),
        .key_level (level_s)
    );

    assign kif.key_level     = level_s;
    assign kif.press_pulse   = press_q;
    assign kif.release_pulse = release_q;
    assign kif.short_press   = short_q;
    assign kif.long_press    = long_q;
    assign kif.repeat_pulse  = repeat_q;

    // Next state and pulse decode; a falling level always takes priority
    // over a long-press or repeat that would fire in the same cycle
    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        rep_cnt_d  = rep_cnt_q;
        press_d    = 1'b0;
        release_d  = 1'b0;
        short_d    = 1'b0;
        long_d     = 1'b0;
        repeat_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                hold_cnt_d = '0;
                rep_cnt_d  = '0;
                if (level_s) begin
                    press_d = 1'b1;
                    state_d = ST_HELD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_HELD: begin
                if (!level_s) begin
                    release_d  = 1'b1;
                    short_d    = 1'b1;
                    hold_cnt_d = '0;
                    state_d    = ST_IDLE;
                end else if (hold_cnt_q == HOLD_LAST) begin
                    long_d     = 1'b1;
                    hold_cnt_d = '0;
                    rep_cnt_d  = '0;
                    state_d    = ST_LONG;
                end else begin
                    hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                end
            end
            ST_LONG: begin
                if (!level_s) begin
                    release_d  = 1'b1;
                    hold_cnt_d = '0;
                    rep_cnt_d  = '0;
                    state_d    = ST_IDLE;
                end else if (REPEAT_CYCLES > 0) begin
                    if (rep_cnt_q == REP_LAST) begin
                        repeat_d  = 1'b1;
                        rep_cnt_d = '0;
                    end else begin
                        rep_cnt_d = rep_cnt_q + REP_W'(1);
                    end
                end else begin
                    rep_cnt_d = '0;
                end
            end
            default: begin
                hold_cnt_d = '0;
                rep_cnt_d  = '0;
                state_d    = ST_IDLE;
            end
        endcase
    end

    // FSM state, counters and registered event pulses
    always_ff @(posedge clk12MHz or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            hold_cnt_q <= '0;
            rep_cnt_q  <= '0;
            press_q    <= 1'b0;
            release_q  <= 1'b0;
            short_q    <= 1'b0;
            long_q     <= 1'b0;
            repeat_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            rep_cnt_q  <= rep_cnt_d;
            press_q    <= press_d;
            release_q  <= release_d;
            short_q    <= short_d;
            long_q     <= long_d;
            repeat_q   <= repeat_d;
        end
    end

endmodule

// File: tb/tb_key_conditioner.sv
// Directed bench for key_conditioner: dut0 with repeat enabled, dut1 with
// repeat disabled, both driven from the same pin. Timing is counted in
// clock edges after the pin change (edge 1 is the first edge sampling it).
module tb_key_conditioner;

    logic clk12MHz = 1'b0;
    logic rst_n    = 1'b0;
    logic key_raw  = 1'b1;

    int total = 0;
    int bad   = 0;

    // pulse counters and invariant violations, updated on the falling edge
    int n_press0 = 0, n_rel0 = 0, n_short0 = 0, n_long0 = 0, n_rep0 = 0;
    int n_rel1 = 0, n_short1 = 0, n_long1 = 0, n_rep1 = 0;
    int n_viol = 0;

    int b_press0, b_rel0, b_short0, b_long0, b_rep0, b_short1, b_long1, b_rep1;

    key_conditioner_if kif0 ();
    key_conditioner_if kif1 ();

    assign kif0.key_raw = key_raw;
    assign kif1.key_raw = key_raw;

    key_conditioner #(
        .DEBOUNCE_CYCLES (4),
        .LONG_CYCLES     (20),
        .REPEAT_CYCLES   (5),
        .KEY_ACTIVE_LOW  (1'b1)
    ) dut0 (
        .clk12MHz (clk12MHz),
        .rst_n    (rst_n),
        .kif      (kif0)
    );

    key_conditioner #(
        .DEBOUNCE_CYCLES (4),
        .LONG_CYCLES     (20),
        .REPEAT_CYCLES   (0),
        .KEY_ACTIVE_LOW  (1'b1)
    ) dut1 (
        .clk12MHz (clk12MHz),
        .rst_n    (rst_n),
        .kif      (kif1)
    );

    // 12 MHz-ish clock (period is arbitrary in simulation)
    always #5 clk12MHz = ~clk12MHz;

    // Pulse counting and per-cycle invariant monitoring
    always @(negedge clk12MHz) begin
        n_press0 <= n_press0 + int'(kif0.press_pulse);
        n_rel0   <= n_rel0   + int'(kif0.release_pulse);
        n_short0 <= n_short0 + int'(kif0.short_press);
        n_long0  <= n_long0  + int'(kif0.long_press);
        n_rep0   <= n_rep0   + int'(kif0.repeat_pulse);
        n_rel1   <= n_rel1   + int'(kif1.release_pulse);
        n_short1 <= n_short1 + int'(kif1.short_press);
        n_long1  <= n_long1  + int'(kif1.long_press);
        n_rep1   <= n_rep1   + int'(kif1.repeat_pulse);
        if ((int'(kif0.press_pulse) + int'(kif0.long_press) + int'(kif0.repeat_pulse) > 1) ||
            (kif0.short_press && kif0.long_press) ||
            (int'(kif1.press_pulse) + int'(kif1.long_press) + int'(kif1.repeat_pulse) > 1) ||
            (kif1.short_press && kif1.long_press) || kif1.repeat_pulse) begin
            n_viol <= n_viol + 1;
        end
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk12MHz);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total = total + 1;
        assert (obs === exp) else begin
            bad = bad + 1;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        // ---- reset with the key held down
        rst_n   = 1'b0;
        key_raw = 1'b0;
        tick(3);
        chk("rst_level0",   kif0.key_level,     1'b0);
        chk("rst_press0",   kif0.press_pulse,   1'b0);
        chk("rst_release0", kif0.release_pulse, 1'b0);
        chk("rst_short0",   kif0.short_press,   1'b0);
        chk("rst_long0",    kif0.long_press,    1'b0);
        chk("rst_repeat0",  kif0.repeat_pulse,  1'b0);
        chk("rst_level1",   kif1.key_level,     1'b0);
        rst_n = 1'b1;
        tick(5);
        chk("rst_level_e5", kif0.key_level,   1'b0);
        tick(1);
        chk("rst_level_e6", kif0.key_level,   1'b1);
        chk("rst_press_e6", kif0.press_pulse, 1'b0);
        tick(1);
        chk("rst_press_e7",  kif0.press_pulse, 1'b1);
        chk("rst_press1_e7", kif1.press_pulse, 1'b1);
        tick(1);
        chk("rst_press_e8", kif0.press_pulse, 1'b0);
        key_raw = 1'b1;
        tick(12);
        chk("idle_level", kif0.key_level, 1'b0);

        // ---- bounce: five 3-cycle lows separated by 2-cycle highs
        b_press0 = n_press0;
        b_rel0   = n_rel0;
        for (int i = 0; i < 5; i++) begin
            key_raw = 1'b0;
            tick(3);
            key_raw = 1'b1;
            tick(2);
        end
        chk("bounce_level",   kif0.key_level,      1'b0);
        chk("bounce_press",   n_press0 - b_press0, 0);
        chk("bounce_release", n_rel0 - b_rel0,     0);
        // a low held long enough is accepted
        key_raw = 1'b0;
        tick(5);
        chk("deb_level_e5", kif0.key_level, 1'b0);
        tick(1);
        chk("deb_level_e6", kif0.key_level, 1'b1);
        tick(1);
        chk("deb_press", kif0.press_pulse, 1'b1);
        chk("deb_press_once", n_press0 - b_press0, 0);

        // ---- short press: release 12 cycles after press_pulse
        b_long0 = n_long0;
        tick(5);
        key_raw = 1'b1;
        tick(6);
        chk("sp_level_fall",  kif0.key_level,     1'b0);
        chk("sp_release_pre", kif0.release_pulse, 1'b0);
        tick(1);
        chk("sp_release", kif0.release_pulse, 1'b1);
        chk("sp_short",   kif0.short_press,   1'b1);
        chk("sp_nolong",  kif0.long_press,    1'b0);
        tick(1);
        chk("sp_release_end", kif0.release_pulse, 1'b0);
        chk("sp_short_end",   kif0.short_press,   1'b0);
        chk("sp_long_count",  n_long0 - b_long0,  0);
        chk("sp_press_count", n_press0 - b_press0, 1);

        // ---- long press with repeats; release lands on a repeat slot
        tick(4);
        b_long0 = n_long0;  b_rep0 = n_rep0;  b_short0 = n_short0;
        b_long1 = n_long1;  b_rep1 = n_rep1;  b_short1 = n_short1;
        key_raw = 1'b0;
        tick(7);
        chk("lp_press", kif0.press_pulse, 1'b1);
        tick(19);
        chk("lp_long_p19", kif0.long_press, 1'b0);
        tick(1);
        chk("lp_long_p20",  kif0.long_press, 1'b1);
        chk("lp_long1_p20", kif1.long_press, 1'b1);
        tick(4);
        chk("lp_rep_p24", kif0.repeat_pulse, 1'b0);
        tick(1);
        chk("lp_rep_p25",  kif0.repeat_pulse, 1'b1);
        chk("lp_rep1_p25", kif1.repeat_pulse, 1'b0);
        tick(1);
        chk("lp_rep_p26", kif0.repeat_pulse, 1'b0);
        tick(4);
        chk("lp_rep_p30", kif0.repeat_pulse, 1'b1);
        tick(3);
        key_raw = 1'b1;
        tick(2);
        chk("lp_rep_p35", kif0.repeat_pulse, 1'b1);
        tick(5);
        chk("lp_release",   kif0.release_pulse, 1'b1);
        chk("lp_rel_norep", kif0.repeat_pulse,  1'b0);
        chk("lp_noshort",   kif0.short_press,   1'b0);
        chk("lp_release1",  kif1.release_pulse, 1'b1);
        chk("lp_noshort1",  kif1.short_press,   1'b0);
        tick(2);
        chk("lp_long_count",   n_long0 - b_long0,   1);
        chk("lp_rep_count",    n_rep0 - b_rep0,     3);
        chk("lp_short_count",  n_short0 - b_short0, 0);
        chk("lp_long_count1",  n_long1 - b_long1,   1);
        chk("lp_short_count1", n_short1 - b_short1, 0);

        // ---- race: level falls on the cycle hold_cnt reaches 19
        tick(4);
        b_long0 = n_long0;  b_short0 = n_short0;
        b_long1 = n_long1;  b_short1 = n_short1;
        key_raw = 1'b0;
        tick(7);
        chk("race_press", kif0.press_pulse, 1'b1);
        tick(13);
        key_raw = 1'b1;
        tick(6);
        chk("race_level_fall", kif0.key_level, 1'b0);
        tick(1);
        chk("race_short",   kif0.short_press,   1'b1);
        chk("race_nolong",  kif0.long_press,    1'b0);
        chk("race_release", kif0.release_pulse, 1'b1);
        chk("race_short1",  kif1.short_press,   1'b1);
        tick(2);
        chk("race_long_count",   n_long0 - b_long0,   0);
        chk("race_short_count",  n_short0 - b_short0, 1);
        chk("race_long_count1",  n_long1 - b_long1,   0);

        // ---- 100-cycle hold: dut1 never repeats, dut0 repeats 17 times
        tick(4);
        b_long0 = n_long0;  b_rep0 = n_rep0;
        b_long1 = n_long1;  b_rep1 = n_rep1;
        key_raw = 1'b0;
        tick(106);
        key_raw = 1'b1;
        tick(10);
        chk("nr_long_count1", n_long1 - b_long1, 1);
        chk("nr_rep_count1",  n_rep1 - b_rep1,   0);
        chk("nr_long_count0", n_long0 - b_long0, 1);
        chk("nr_rep_count0",  n_rep0 - b_rep0,   17);

        // ---- reset in the middle of a press
        tick(4);
        b_press0 = n_press0;
        b_rel0   = n_rel0;
        key_raw  = 1'b0;
        tick(10);
        chk("mr_held", kif0.key_level, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("mr_level_cleared", kif0.key_level,     1'b0);
        chk("mr_release_none",  kif0.release_pulse, 1'b0);
        tick(2);
        rst_n = 1'b1;
        tick(6);
        chk("mr_level_e6", kif0.key_level,   1'b1);
        chk("mr_press_e6", kif0.press_pulse, 1'b0);
        tick(1);
        chk("mr_press_e7", kif0.press_pulse, 1'b1);
        tick(1);
        chk("mr_press_count", n_press0 - b_press0, 2);
        chk("mr_rel_count",   n_rel0 - b_rel0,     0);
        key_raw = 1'b1;
        tick(12);
        chk("mr_rel_after", n_rel0 - b_rel0, 1);

        chk("invariants", n_viol, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/key_conditioner.md
Name: key_conditioner

Overview:
Conditions the raw push-button pin before it reaches the sound and blink stages.
- Synchronises and debounces the pin, normalised to active-high.
- Emits single-cycle press/release events, and classifies each press as short or long.
- Emits auto-repeat ticks while a long press is held.
- press_pulse is the intended driver of the sound stage's startPlaying; key_level replaces raw key1 for the blink stage.

Parameters:
DEBOUNCE_CYCLES, 120000, consecutive stable cycles required to accept a level change (10 ms at 12 MHz); minimum 1
LONG_CYCLES, 6000000, cycles key_level must stay high before long_press (0.5 s); minimum 1
REPEAT_CYCLES, 1200000, period of repeat_pulse in the long-press state (100 ms); 0 disables repeat
KEY_ACTIVE_LOW, 1, 1 = pin reads 0 when pressed

Ports:
clk12MHz  in  1  system clock, 12 MHz
rst_n  in  1  asynchronous active-low reset
key_raw  in  1  asynchronous button pin
key_level  out  1  debounced pressed level, active-high
press_pulse  out  1  one cycle at start of a debounced press
release_pulse  out  1  one cycle at end of a debounced press
short_press  out  1  one cycle on release of a press shorter than LONG_CYCLES
long_press  out  1  one cycle when a held press reaches LONG_CYCLES
repeat_pulse  out  1  one cycle every REPEAT_CYCLES while in LONG

Behaviour:
- Reset values: all outputs 0; sync flops = inactive pin level (1 if KEY_ACTIVE_LOW); counters 0; FSM IDLE.
- Synchroniser:
  - Two flops on key_raw.
  - The second flop XOR KEY_ACTIVE_LOW gives key_sync (1 = pressed).
- Debounce:
  - db_cnt clears whenever key_sync == key_level.
  - Otherwise db_cnt increments.
  - At the edge where db_cnt == DEBOUNCE_CYCLES-1 and key_sync != key_level: key_level toggles and db_cnt clears.
  - Latency from a clean pin edge to the key_level change: 2 + DEBOUNCE_CYCLES clocks.
  - A glitch shorter than DEBOUNCE_CYCLES never changes key_level.
- FSM (IDLE, HELD, LONG), evaluated on registered key_level; all pulses are registered outputs:
  - IDLE:
    - key_level=1 -> HELD, hold_cnt=0.
    - press_pulse is high in the first cycle key_level reads 1.
  - HELD, key_level=0:
    - release_pulse and short_press both high in the first cycle key_level reads 0.
    - -> IDLE.
  - HELD, key_level=1:
    - hold_cnt increments.
    - When hold_cnt reaches LONG_CYCLES-1: long_press pulses, rep_cnt=0, -> LONG.
  - LONG, key_level=1, REPEAT_CYCLES>0:
    - rep_cnt counts 0..REPEAT_CYCLES-1 and wraps.
    - repeat_pulse is high on each wrap.
    - The first repeat comes REPEAT_CYCLES cycles after long_press.
  - LONG, key_level=0:
    - release_pulse only, no short_press.
    - -> IDLE, counters cleared.
- Simultaneous events:
  - If key_level falls in the same cycle hold_cnt would reach threshold, release wins: short_press, no long_press.
  - The same rule applies in LONG: release beats repeat.
- Invariants:
  - At most one of press_pulse / long_press / repeat_pulse per cycle.
  - short_press and long_press are never both issued for one press.
- Counter widths: $clog2 of parameter + 1; counters never exceed their parameter.
- Reset mid-press:
  - Everything returns to reset values immediately and no release event is generated.
  - If the key is still held after reset deasserts, a fresh press_pulse follows 2 + DEBOUNCE_CYCLES clocks later.

Decomposition:
- Shared package key_cond_pkg:
  - FSM state encoding: IDLE=0, HELD=1, LONG=2.
  - Default timing constants for 12 MHz.
  - Helper function for counter width.
- One natural sub-module, key_debounce:
  - Synchroniser plus debounce counter.
  - Ports: clk12MHz, rst_n, key_raw -> key_level.
  - Parameters: DEBOUNCE_CYCLES, KEY_ACTIVE_LOW.
- The top-level key_conditioner keeps the FSM and pulse logic.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=4, LONG_CYCLES=20, REPEAT_CYCLES=5, KEY_ACTIVE_LOW=1.
- Reset: rst_n=0 with key_raw=0 (pressed) -> all outputs 0; release rst_n -> key_level=1 and press_pulse exactly 6 clocks later.
- Bounce: key_raw pulses low for 3 cycles, five times, separated by 2-cycle highs -> key_level stays 0, no pulses; a low held for 4+ cycles -> press_pulse once.
- Short press: key low for 12 cycles after debounce -> press_pulse, then release_pulse + short_press in the same cycle, no long_press.
- Long press: key held 40 cycles past debounce -> long_press 20 cycles after press_pulse, then repeat_pulse every 5 cycles; on release -> release_pulse, no short_press.
- Race: key_level falls exactly on the cycle hold_cnt hits 19 -> short_press=1, long_press=0.
- Repeat disabled (REPEAT_CYCLES=0): hold 100 cycles -> exactly one long_press, zero repeat_pulse.
